// File: rtl/ram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ram_arbiter_pkg : shared state encoding and default widths  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package ram_arbiter_pkg;

  localparam int DEF_AW = 4;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2 : combinational 2-way round-robin picker  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  assign valid = |req;
  // Under contention the client that did not win last time goes next.
  assign winner = (req == 2'b11) ? ~last : req[1];

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter : two-client round-robin read/write sequencer for a 16x8 RAM  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_inaddr,
  output logic [AW-1:0] ram_outaddr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  state_t        state;
  state_t        state_next;
  logic          last;
  logic          pick_valid;
  logic          pick_winner;
  logic          grant_now;
  logic          resp_now;
  logic          cmd_we;
  logic          cmd_owner;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  rr_pick2 u_pick (
    .req    (req),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_next;
  end

  // ram_we is decoded from state so an asynchronous reset in CMD kills it at once.
  always_comb begin
    state_next = state;
    grant_now  = 1'b0;
    resp_now   = 1'b0;
    ram_we     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_now  = 1'b1;
          state_next = CMD;
        end
      end
      CMD: begin
        ram_we     = cmd_we;
        state_next = cmd_we ? IDLE : RESP;
      end
      RESP: begin
        resp_now   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      gnt       <= 2'b00;
      rvalid    <= 2'b00;
      rdata     <= '0;
      last      <= 1'b1;
      cmd_we    <= 1'b0;
      cmd_owner <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      gnt    <= 2'b00;
      rvalid <= 2'b00;
      if (grant_now) begin
        cmd_we    <= we[pick_winner];
        cmd_owner <= pick_winner;
        cmd_addr  <= pick_winner ? addr1 : addr0;
        cmd_wdata <= pick_winner ? wdata1 : wdata0;
        last      <= pick_winner;
        gnt       <= pick_winner ? 2'b10 : 2'b01;
      end
      if (resp_now) begin
        rdata  <= ram_dout;
        rvalid <= cmd_owner ? 2'b10 : 2'b01;
      end
    end
  end

  assign ram_inaddr  = cmd_addr;
  assign ram_outaddr = cmd_addr;
  assign ram_din     = cmd_wdata;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter : directed + random transactions against a RAM/arbitration model  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [1:0]    we = 2'b00;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] wdata0 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          ram_we;
  logic [AW-1:0] ram_inaddr;
  logic [AW-1:0] ram_outaddr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  // RAM stand-in with a preload port used only while the arbiter is in reset
  logic [DW-1:0] mem [16];
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;

  // Reference model: expected memory contents, round-robin history, held rdata
  logic [DW-1:0] model_mem [16];
  logic          model_last;
  logic [DW-1:0] model_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en)     mem[load_addr] <= load_data;
    else if (ram_we) mem[ram_inaddr] <= ram_din;
    if (!ram_we)     ram_dout <= mem[ram_outaddr];
  end

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .req         (req),
    .we          (we),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .busy        (busy),
    .ram_we      (ram_we),
    .ram_inaddr  (ram_inaddr),
    .ram_outaddr (ram_outaddr),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; E0 is the first edge after req is presented.
  task automatic txn(input logic [1:0] r, input logic [1:0] w,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input bit hold, input bit scramble);
    logic          win;
    logic          exp_we;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    if (r == 2'b11)      win = (model_last == 1'b0);
    else if (r == 2'b01) win = 1'b0;
    else                 win = 1'b1;
    exp_we = w[win];
    ea     = win ? a1 : a0;
    ed     = win ? d1 : d0;

    tick();  // E0
    check("gnt", {30'd0, gnt}, win ? 32'd2 : 32'd1);
    check("rvalid_pulse", {30'd0, rvalid}, 32'd0);
    check("busy_cmd", {31'd0, busy}, 32'd1);
    check("ram_we_cmd", {31'd0, ram_we}, {31'd0, exp_we});
    if (exp_we) begin
      check("ram_inaddr", {28'd0, ram_inaddr}, {28'd0, ea});
      check("ram_din", {24'd0, ram_din}, {24'd0, ed});
    end else begin
      check("ram_outaddr", {28'd0, ram_outaddr}, {28'd0, ea});
    end
    if (!hold) req = 2'b00;
    if (scramble) begin
      addr0 = ~a0; addr1 = ~a1; wdata0 = ~d0; wdata1 = ~d1;
    end
    model_last = win;

    tick();  // E1
    check("gnt_clear", {30'd0, gnt}, 32'd0);
    check("ram_we_off", {31'd0, ram_we}, 32'd0);
    if (exp_we) begin
      model_mem[ea] = ed;
      check("busy_wr_done", {31'd0, busy}, 32'd0);
      check("rdata_held", {24'd0, rdata}, {24'd0, model_rdata});
    end else begin
      check("busy_resp", {31'd0, busy}, 32'd1);
      check("rvalid_early", {30'd0, rvalid}, 32'd0);
      check("outaddr_resp", {28'd0, ram_outaddr}, {28'd0, ea});
      tick();  // E2
      model_rdata = model_mem[ea];
      check("rvalid", {30'd0, rvalid}, win ? 32'd2 : 32'd1);
      check("rdata", {24'd0, rdata}, {24'd0, model_rdata});
      check("busy_rd_done", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset with both clients requesting; preload RAM meanwhile.
    clrn = 1'b0;
    req  = 2'b11;
    #1;
    for (int i = 0; i < 16; i++) begin
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = DW'((i * 8'h1D) ^ 8'h5A);
      model_mem[i] = load_data;
      tick();
    end
    load_en = 1'b0;
    check("reset_outputs",
          {2'd0, gnt, rvalid, rdata, busy, ram_we, ram_inaddr, ram_outaddr, ram_din}, 32'd0);
    tick();
    check("reset_no_gnt", {30'd0, gnt}, 32'd0);
    model_last  = 1'b1;
    model_rdata = '0;
    clrn = 1'b1;

    // First conflict after reset goes to client 0.
    txn(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 1'b0, 1'b0);

    // Client 0 write then read back.
    txn(2'b01, 2'b01, 4'h3, 4'h0, 8'hA5, 8'h00, 1'b0, 1'b0);
    txn(2'b01, 2'b00, 4'h3, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Contention: both hold reads, grants must alternate.
    for (int k = 0; k < 4; k++)
      txn(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, (k < 3), 1'b0);

    // Inputs change after the grant; the latched command must win.
    txn(2'b10, 2'b10, 4'h0, 4'h7, 8'h00, 8'h3C, 1'b0, 1'b1);
    txn(2'b10, 2'b00, 4'h0, 4'h7, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset during CMD of a write aborts it.
    req = 2'b01; we = 2'b01; addr0 = 4'h5; wdata0 = 8'hFF;
    tick();
    check("abort_we_before", {31'd0, ram_we}, 32'd1);
    req = 2'b00;
    #2 clrn = 1'b0;
    #1;
    check("abort_we_dropped", {31'd0, ram_we}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    model_last  = 1'b1;
    model_rdata = '0;
    tick();
    tick();
    clrn = 1'b1;
    txn(2'b01, 2'b00, 4'h5, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Held read request: a new read every three cycles.
    for (int k = 0; k < 4; k++)
      txn(2'b01, 2'b00, AW'(k), 4'h0, 8'h00, 8'h00, (k < 3), 1'b0);

    // Random traffic with occasional idle gaps.
    for (int k = 0; k < 60; k++) begin
      txn(2'($urandom_range(1, 3)), 2'($urandom), AW'($urandom), AW'($urandom),
          DW'($urandom), DW'($urandom), 1'b0, 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_gnt", {30'd0, gnt}, 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
